// File: rtl/ysyx_25060170_stage_buf_if.sv
// ysyx_25060170_stage_buf_if
// Upstream/downstream valid/ready channel pair for one pipeline stage buffer.
//   in_valid/in_ready/in_data    : beat offered by the producing stage
//   out_valid/out_ready/out_data : beat presented to the consuming stage
// Handshake: a beat moves across a side on a rising clk edge exactly when
// valid and ready are both high in that cycle. A producer that raises valid
// keeps valid and data stable until the transfer happens (flush excepted);
// ready may change freely and never waits on valid.
// Modports: master = the surrounding pipeline (drives in_*, out_ready),
//           slave  = the buffer itself.
`timescale 1ns/1ps
interface ysyx_25060170_stage_buf_if #(
    parameter int DATA_W = 128
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/ysyx_25060170_stage_buf.sv
// ysyx_25060170_stage_buf
// Generic inter-stage register with valid/ready handshake, opaque payload,
// synchronous flush, occupancy and a saturating back-pressure counter.
// Parameters:
//   DATA_W : payload width (1..1024)
//   SKID   : 0 = one entry, in_ready passes out_ready through combinationally
//            1 = main + skid entry, in_ready depends on registered state only
// Ports:
//   clk, rst     : clock, asynchronous active-low reset
//   bus          : slave side of the in/out valid/ready channel pair
//   flush        : drop every held beat and any beat accepted this cycle
//   occupancy    : number of held beats (0..2)
//   stall_cnt    : cycles with out_valid & ~out_ready, saturating
//   state_dbg    : raw state register (EMPTY=0, ONE=1, TWO=2)
`timescale 1ns/1ps
module ysyx_25060170_stage_buf #(
    parameter int DATA_W = 128,
    parameter bit SKID   = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    ysyx_25060170_stage_buf_if.slave  bus,
    input  logic                      flush,
    output logic [1:0]                occupancy,
    output logic [31:0]               stall_cnt,
    output logic [1:0]                state_dbg
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t            state_q;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;
    logic [31:0]       stall_q;
    logic              in_ready_c;
    logic              in_fire;
    logic              out_fire;

    // The encoding equals the number of held beats.
    assign occupancy     = state_q;
    assign state_dbg     = state_q;
    assign stall_cnt     = stall_q;
    assign bus.out_valid = (state_q != EMPTY);
    assign bus.out_data  = main_q;
    assign bus.in_ready  = in_ready_c;

    // in_ready is held low while reset is asserted so no beat is taken
    // by a buffer whose state is being forced.
    always_comb begin
        in_ready_c = 1'b0;
        if (SKID) begin
            in_ready_c = rst & (state_q != TWO);
        end else begin
            in_ready_c = rst & ((state_q == EMPTY) | bus.out_ready);
        end
    end

    assign in_fire  = bus.in_valid & in_ready_c;
    assign out_fire = bus.out_valid & bus.out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            stall_q <= '0;
        end else begin
            // Counts every stalled cycle, flushed or not.
            if (bus.out_valid && !bus.out_ready && (stall_q != 32'hFFFF_FFFF)) begin
                stall_q <= stall_q + 32'd1;
            end

            if (flush) begin
                state_q <= EMPTY;
                main_q  <= '0;
                skid_q  <= '0;
            end else begin
                case (state_q)
                    EMPTY: begin
                        if (in_fire) begin
                            main_q  <= bus.in_data;
                            state_q <= ONE;
                        end
                    end
                    ONE: begin
                        // With SKID=0, in_fire in ONE implies out_fire, so the
                        // skid branch is unreachable in that mode.
                        if (in_fire && out_fire) begin
                            main_q <= bus.in_data;
                        end else if (in_fire) begin
                            skid_q  <= bus.in_data;
                            state_q <= TWO;
                        end else if (out_fire) begin
                            // Keep out_data at zero whenever the buffer is empty.
                            main_q  <= '0;
                            state_q <= EMPTY;
                        end
                    end
                    TWO: begin
                        if (out_fire) begin
                            main_q  <= skid_q;
                            state_q <= ONE;
                        end
                    end
                    default: begin
                        main_q  <= '0;
                        skid_q  <= '0;
                        state_q <= EMPTY;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ysyx_25060170_stage_buf.sv
// tb_ysyx_25060170_stage_buf
// Exercises a SKID=1 and a SKID=0 instance (both DATA_W=32) side by side.
`timescale 1ns/1ps
module tb_ysyx_25060170_stage_buf;

    logic        clk;
    logic        rst;
    logic        flush1, flush0;
    logic [1:0]  occ1, occ0;
    logic [31:0] stall1, stall0;
    logic [1:0]  dbg1, dbg0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_stall1 = 32'd0;
    logic [31:0] exp_stall0 = 32'd0;

    ysyx_25060170_stage_buf_if #(.DATA_W(32)) bus1 ();
    ysyx_25060170_stage_buf_if #(.DATA_W(32)) bus0 ();

    ysyx_25060170_stage_buf #(.DATA_W(32), .SKID(1'b1)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus1),
        .flush     (flush1),
        .occupancy (occ1),
        .stall_cnt (stall1),
        .state_dbg (dbg1)
    );

    ysyx_25060170_stage_buf #(.DATA_W(32), .SKID(1'b0)) u_pass (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus0),
        .flush     (flush0),
        .occupancy (occ0),
        .stall_cnt (stall0),
        .state_dbg (dbg0)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- drivers ----------------
    task automatic drive(input int s, input logic v, input logic [31:0] d,
                         input logic r, input logic f);
        if (s == 1) begin
            bus1.in_valid = v; bus1.in_data = d; bus1.out_ready = r; flush1 = f;
        end else begin
            bus0.in_valid = v; bus0.in_data = d; bus0.out_ready = r; flush0 = f;
        end
    endtask

    task automatic sample(input int s, output logic ir, output logic ov,
                          output logic [31:0] od, output logic [1:0] oc,
                          output logic [31:0] sc);
        if (s == 1) begin
            ir = bus1.in_ready; ov = bus1.out_valid; od = bus1.out_data; oc = occ1; sc = stall1;
        end else begin
            ir = bus0.in_ready; ov = bus0.out_valid; od = bus0.out_data; oc = occ0; sc = stall0;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic ir, ov; logic [31:0] od, sc; logic [1:0] oc;
        rst = 1'b0;
        drive(1, 1'b0, 32'd0, 1'b0, 1'b0);
        drive(0, 1'b0, 32'd0, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            tick();
            for (int s = 0; s < 2; s++) begin
                sample(s, ir, ov, od, oc, sc);
                n_tests++;
                if ({ir, ov, od, oc, sc} !== 67'd0) begin
                    n_fail++;
                    $display("FAIL reset_hold dut%0d: got ir=%b ov=%b od=%h occ=%0d stall=%h expected all zero",
                             s, ir, ov, od, oc, sc);
                end
            end
        end
        rst = 1'b1;
        exp_stall1 = 32'd0;
        exp_stall0 = 32'd0;
        tick();
        for (int s = 0; s < 2; s++) begin
            sample(s, ir, ov, od, oc, sc);
            n_tests++;
            if ({ir, ov, od, oc, sc} !== {1'b1, 1'b0, 32'd0, 2'd0, 32'd0}) begin
                n_fail++;
                $display("FAIL reset_release dut%0d: got ir=%b ov=%b od=%h occ=%0d stall=%h expected ir=1 rest zero",
                         s, ir, ov, od, oc, sc);
            end
        end
    endtask

    task automatic test_stream();
        logic ir, ov; logic [31:0] od, sc; logic [1:0] oc;
        logic [31:0] pat [3];
        pat = '{32'h11, 32'h22, 32'h33};
        for (int i = 0; i < 3; i++) begin
            drive(1, 1'b1, pat[i], 1'b1, 1'b0);
            #1;
            sample(1, ir, ov, od, oc, sc);
            n_tests++;
            if (ir !== 1'b1) begin
                n_fail++;
                $display("FAIL stream_in_ready beat%0d: got %b expected 1", i, ir);
            end
            tick();
            sample(1, ir, ov, od, oc, sc);
            n_tests++;
            if ({ov, od, oc} !== {1'b1, pat[i], 2'd1}) begin
                n_fail++;
                $display("FAIL stream_out beat%0d: got ov=%b od=%h occ=%0d expected ov=1 od=%h occ=1",
                         i, ov, od, oc, pat[i]);
            end
        end
        drive(1, 1'b0, 32'd0, 1'b1, 1'b0);
        tick();
        sample(1, ir, ov, od, oc, sc);
        n_tests++;
        if ({ov, od, oc, sc} !== {1'b0, 32'd0, 2'd0, exp_stall1}) begin
            n_fail++;
            $display("FAIL stream_drain: got ov=%b od=%h occ=%0d stall=%h expected empty stall=%h",
                     ov, od, oc, sc, exp_stall1);
        end
        drive(1, 1'b0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        logic ir, ov; logic [31:0] od, sc; logic [1:0] oc;
        drive(1, 1'b1, 32'hA1, 1'b1, 1'b0);
        tick();
        drive(1, 1'b1, 32'hA2, 1'b0, 1'b0);
        #1;
        sample(1, ir, ov, od, oc, sc);
        n_tests++;
        if ({ir, ov, od, oc} !== {1'b1, 1'b1, 32'hA1, 2'd1}) begin
            n_fail++;
            $display("FAIL bp_first: got ir=%b ov=%b od=%h occ=%0d expected ir=1 ov=1 od=a1 occ=1", ir, ov, od, oc);
        end
        tick();
        exp_stall1 = exp_stall1 + 32'd1;
        drive(1, 1'b1, 32'hA3, 1'b0, 1'b0);
        #1;
        sample(1, ir, ov, od, oc, sc);
        n_tests++;
        if ({ir, od, oc, sc} !== {1'b0, 32'hA1, 2'd2, exp_stall1}) begin
            n_fail++;
            $display("FAIL bp_full: got ir=%b od=%h occ=%0d stall=%h expected ir=0 od=a1 occ=2 stall=%h",
                     ir, od, oc, sc, exp_stall1);
        end
        tick();
        exp_stall1 = exp_stall1 + 32'd1;
        sample(1, ir, ov, od, oc, sc);
        n_tests++;
        if ({ir, od, oc, sc} !== {1'b0, 32'hA1, 2'd2, exp_stall1}) begin
            n_fail++;
            $display("FAIL bp_hold: got ir=%b od=%h occ=%0d stall=%h expected ir=0 od=a1 occ=2 stall=%h",
                     ir, od, oc, sc, exp_stall1);
        end
        drive(1, 1'b1, 32'hA3, 1'b1, 1'b0);
        tick();
        sample(1, ir, ov, od, oc, sc);
        n_tests++;
        if ({ir, ov, od, oc} !== {1'b1, 1'b1, 32'hA2, 2'd1}) begin
            n_fail++;
            $display("FAIL bp_release_a2: got ir=%b ov=%b od=%h occ=%0d expected ir=1 ov=1 od=a2 occ=1", ir, ov, od, oc);
        end
        tick();
        drive(1, 1'b0, 32'd0, 1'b1, 1'b0);
        sample(1, ir, ov, od, oc, sc);
        n_tests++;
        if ({ov, od, oc} !== {1'b1, 32'hA3, 2'd1}) begin
            n_fail++;
            $display("FAIL bp_release_a3: got ov=%b od=%h occ=%0d expected ov=1 od=a3 occ=1", ov, od, oc);
        end
        tick();
        sample(1, ir, ov, od, oc, sc);
        n_tests++;
        if ({ov, od, oc, sc} !== {1'b0, 32'd0, 2'd0, exp_stall1}) begin
            n_fail++;
            $display("FAIL bp_drain: got ov=%b od=%h occ=%0d stall=%h expected empty stall=%h",
                     ov, od, oc, sc, exp_stall1);
        end
        drive(1, 1'b0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic test_passthrough();
        logic ir, ov; logic [31:0] od, sc; logic [1:0] oc;
        drive(0, 1'b1, 32'h55, 1'b0, 1'b0);
        #1;
        sample(0, ir, ov, od, oc, sc);
        n_tests++;
        if (ir !== 1'b1) begin
            n_fail++;
            $display("FAIL pass_empty_ready: got %b expected 1", ir);
        end
        tick();
        drive(0, 1'b1, 32'h66, 1'b0, 1'b0);
        #1;
        sample(0, ir, ov, od, oc, sc);
        n_tests++;
        if ({ir, ov, od, oc} !== {1'b0, 1'b1, 32'h55, 2'd1}) begin
            n_fail++;
            $display("FAIL pass_full_blocked: got ir=%b ov=%b od=%h occ=%0d expected ir=0 ov=1 od=55 occ=1", ir, ov, od, oc);
        end
        tick();
        exp_stall0 = exp_stall0 + 32'd1;
        drive(0, 1'b1, 32'h66, 1'b1, 1'b0);
        #1;
        sample(0, ir, ov, od, oc, sc);
        n_tests++;
        if ({ir, od} !== {1'b1, 32'h55}) begin
            n_fail++;
            $display("FAIL pass_comb_ready: got ir=%b od=%h expected ir=1 od=55", ir, od);
        end
        tick();
        drive(0, 1'b0, 32'd0, 1'b1, 1'b0);
        #1;
        sample(0, ir, ov, od, oc, sc);
        n_tests++;
        if ({ov, od, oc, sc} !== {1'b1, 32'h66, 2'd1, exp_stall0}) begin
            n_fail++;
            $display("FAIL pass_replace: got ov=%b od=%h occ=%0d stall=%h expected ov=1 od=66 occ=1 stall=%h",
                     ov, od, oc, sc, exp_stall0);
        end
        tick();
        sample(0, ir, ov, od, oc, sc);
        n_tests++;
        if ({ov, od, oc} !== {1'b0, 32'd0, 2'd0}) begin
            n_fail++;
            $display("FAIL pass_drain: got ov=%b od=%h occ=%0d expected empty", ov, od, oc);
        end
        drive(0, 1'b0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic test_flush();
        logic ir, ov; logic [31:0] od, sc; logic [1:0] oc;
        drive(1, 1'b1, 32'hB1, 1'b0, 1'b0);
        tick();
        drive(1, 1'b1, 32'hB2, 1'b0, 1'b0);
        tick();
        exp_stall1 = exp_stall1 + 32'd1;
        sample(1, ir, ov, od, oc, sc);
        n_tests++;
        if ({ir, oc} !== {1'b0, 2'd2}) begin
            n_fail++;
            $display("FAIL flush_fill: got ir=%b occ=%0d expected ir=0 occ=2", ir, oc);
        end
        drive(1, 1'b1, 32'hFF, 1'b1, 1'b1);
        tick();
        drive(1, 1'b0, 32'd0, 1'b0, 1'b0);
        #1;
        sample(1, ir, ov, od, oc, sc);
        n_tests++;
        if ({ov, od, oc, sc} !== {1'b0, 32'd0, 2'd0, exp_stall1}) begin
            n_fail++;
            $display("FAIL flush_clear: got ov=%b od=%h occ=%0d stall=%h expected empty stall=%h",
                     ov, od, oc, sc, exp_stall1);
        end
        for (int c = 0; c < 2; c++) begin
            tick();
            sample(1, ir, ov, od, oc, sc);
            n_tests++;
            if ({ov, od} !== {1'b0, 32'd0}) begin
                n_fail++;
                $display("FAIL flush_no_ff cycle%0d: got ov=%b od=%h expected ov=0 od=0", c, ov, od);
            end
        end
    endtask

    // Reference: the buffer is a FIFO of accepted beats with capacity 2
    // (SKID=1) or 1 with same-cycle replacement (SKID=0).
    task automatic test_random(input int s, input int n);
        logic ir, ov; logic [31:0] od, sc; logic [1:0] oc;
        logic [31:0] exp_q[$];
        logic iv, r, f, e_ir, e_ov;
        logic [31:0] d, e_od, e_sc;
        e_sc = (s == 1) ? exp_stall1 : exp_stall0;
        for (int c = 0; c < n; c++) begin
            iv = 1'($urandom_range(0, 1));
            r  = ($urandom_range(0, 3) != 0);
            f  = ($urandom_range(0, 19) == 0);
            d  = $urandom;
            drive(s, iv, d, r, f);
            #1;
            sample(s, ir, ov, od, oc, sc);
            e_ir = (s == 1) ? (exp_q.size() < 2) : (exp_q.size() == 0 || r);
            e_ov = (exp_q.size() != 0);
            e_od = 32'd0;
            if (e_ov) e_od = exp_q[0];
            n_tests++;
            if ({ir, ov, od, oc, sc} !== {e_ir, e_ov, e_od, 2'(exp_q.size()), e_sc}) begin
                n_fail++;
                $display("FAIL random dut%0d cycle%0d: got ir=%b ov=%b od=%h occ=%0d stall=%h expected ir=%b ov=%b od=%h occ=%0d stall=%h",
                         s, c, ir, ov, od, oc, sc, e_ir, e_ov, e_od, exp_q.size(), e_sc);
            end
            if (e_ov && !r && e_sc != 32'hFFFF_FFFF) e_sc = e_sc + 32'd1;
            if (e_ov && r) void'(exp_q.pop_front());
            if (f) exp_q.delete();
            else if (iv && e_ir) exp_q.push_back(d);
            tick();
        end
        drive(s, 1'b0, 32'd0, 1'b1, 1'b0);
        tick();
        tick();
        drive(s, 1'b0, 32'd0, 1'b0, 1'b0);
        sample(s, ir, ov, od, oc, sc);
        n_tests++;
        if ({ov, oc, sc} !== {1'b0, 2'd0, e_sc}) begin
            n_fail++;
            $display("FAIL random_drain dut%0d: got ov=%b occ=%0d stall=%h expected empty stall=%h", s, ov, oc, sc, e_sc);
        end
        if (s == 1) exp_stall1 = e_sc;
        else exp_stall0 = e_sc;
    endtask

    task automatic test_saturation();
        logic ir, ov; logic [31:0] od, sc; logic [1:0] oc;
        drive(1, 1'b1, 32'hC1, 1'b1, 1'b0);
        tick();
        drive(1, 1'b0, 32'd0, 1'b0, 1'b0);
        force u_skid.stall_q = 32'hFFFF_FFFE;
        #1;
        release u_skid.stall_q;
        tick();
        sample(1, ir, ov, od, oc, sc);
        n_tests++;
        if ({sc, od} !== {32'hFFFF_FFFF, 32'hC1}) begin
            n_fail++;
            $display("FAIL sat_reach: got stall=%h od=%h expected stall=ffffffff od=c1", sc, od);
        end
        for (int c = 0; c < 2; c++) begin
            tick();
            sample(1, ir, ov, od, oc, sc);
            n_tests++;
            if (sc !== 32'hFFFF_FFFF) begin
                n_fail++;
                $display("FAIL sat_hold cycle%0d: got stall=%h expected ffffffff", c, sc);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic ir, ov; logic [31:0] od, sc; logic [1:0] oc;
        drive(1, 1'b1, 32'hD2, 1'b0, 1'b0);
        tick();
        sample(1, ir, ov, od, oc, sc);
        n_tests++;
        if (oc !== 2'd2) begin
            n_fail++;
            $display("FAIL rstmid_fill: got occ=%0d expected 2", oc);
        end
        rst = 1'b0;
        #1;
        sample(1, ir, ov, od, oc, sc);
        n_tests++;
        if ({ir, ov, od, oc, sc} !== 67'd0) begin
            n_fail++;
            $display("FAIL rstmid_async: got ir=%b ov=%b od=%h occ=%0d stall=%h expected all zero", ir, ov, od, oc, sc);
        end
        drive(1, 1'b0, 32'd0, 1'b1, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        sample(1, ir, ov, od, oc, sc);
        n_tests++;
        if ({ir, ov, od, oc} !== {1'b1, 1'b0, 32'd0, 2'd0}) begin
            n_fail++;
            $display("FAIL rstmid_release: got ir=%b ov=%b od=%h occ=%0d expected ir=1 empty", ir, ov, od, oc);
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_passthrough();
        test_flush();
        test_random(1, 300);
        test_random(0, 300);
        test_saturation();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: got no completion by 200000ns expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "timeout");
    end

endmodule
